booth_r4_seq_mult: RTL

- Iterative signed radix-4 Booth multiplier, one Booth digit per clock.
- Sits directly upstream of the `cla`-based accumulate stage in the MACC. Its 2N-bit product is the addend fed to the CLA accumulator.
- Valid/ready handshake on both the operand side and the product side.

---
 rtl/booth_r4_seq_mult.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - iterative signed radix-4 Booth multiplier, one digit per clock
//
// Purpose:
//   Computes the exact 2N-bit signed product of two N-bit two's complement
//   operands by retiring one radix-4 Booth digit per clock. The product feeds
//   the CLA accumulate stage of the MACC as its addend.
//
// Ports:
//   clk        in   1    clock, all state changes on the rising edge
//   rst        in   1    synchronous active-high reset, dominates everything
//   in_valid   in   1    a_in/b_in carry a valid operand pair
//   in_ready   out  1    block is idle and will accept operands
//   a_in       in   N    signed multiplicand
//   b_in       in   N    signed multiplier
//   out_valid  out  1    product is valid
//   out_ready  in   1    downstream accepts the product
//   product    out  2N   signed product, forced to 0 while out_valid is low
//
// Parameters:
//   N          operand width, even and >= 4
//
// Build options:
//   BOOTH_ZERO_SKIP_EN  when defined, finish as soon as every remaining Booth
//                       digit is known to be zero (latency 1..N/2 edges);
//                       when undefined, latency is always N/2 edges.

module booth_r4_seq_mult #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product
);

    localparam int W      = 2 * N;
    localparam int DIGITS = N / 2;
    localparam int CW     = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Architectural state
    state_t         state_q;
    logic [W-1:0]   a_q;          // sign-extended multiplicand, pre-shifted by 2i
    logic [N-1:0]   b_q;          // multiplier, arithmetically shifted right by 2i
    logic           bm1_q;        // B[2i-1], the overlap bit of the current digit
    logic [W-1:0]   p_q;          // running partial sum
    logic [CW-1:0]  cnt_q;        // index of the digit processed this cycle

    // Registered outputs
    logic           in_ready_q;
    logic           out_valid_q;
    logic [W-1:0]   product_q;

    // Next-state values of the datapath while in RUN
    logic [W-1:0]   a_d;
    logic [N-1:0]   b_d;
    logic           bm1_d;
    logic [W-1:0]   p_d;
    logic [CW-1:0]  cnt_d;

    // Booth digit decode
    logic           dig_one;      // |d| == 1
    logic           dig_two;      // |d| == 2
    logic           dig_neg;      // d negative (or the harmless 111 case)
    logic [W-1:0]   pp_mag;       // |d| * A, already aligned to weight 4^i
    logic [W-1:0]   pp_add;       // one's complement of pp_mag when negative

    logic           last_digit;
    logic           rest_zero;

    // Digit i uses bits (B[2i+1], B[2i], B[2i-1]); because b_q is shifted
    // right by two every step, those are always b_q[1], b_q[0], bm1_q.
    always_comb begin
        dig_one = b_q[0] ^ bm1_q;
        dig_two = (b_q[1] & ~b_q[0] & ~bm1_q) | (~b_q[1] & b_q[0] & bm1_q);
        dig_neg = b_q[1];

        pp_mag = '0;
        if (dig_one) begin
            pp_mag = a_q;
        end else if (dig_two) begin
            pp_mag = {a_q[W-2:0], 1'b0};
        end

        // Negation is invert-plus-one; the +1 enters as the carry-in of the
        // same add. For pattern 111 the magnitude is zero, so ~0 + 1 wraps to 0.
        pp_add = pp_mag ^ {W{dig_neg}};
        p_d    = p_q + pp_add + {{(W-1){1'b0}}, dig_neg};

        a_d    = {a_q[W-3:0], 2'b00};
        b_d    = {{2{b_q[N-1]}}, b_q[N-1:2]};
        bm1_d  = b_q[1];
        cnt_d  = cnt_q + CW'(1);
    end

`ifdef BOOTH_ZERO_SKIP_EN
    // b_q[N-1:1] holds B[N-1:2i+1] padded with copies of the sign bit, so the
    // remaining digits are all zero exactly when this slice is uniform.
    assign rest_zero = (~|b_q[N-1:1]) | (&b_q[N-1:1]);
`else
    assign rest_zero = 1'b0;
`endif

    assign last_digit = (cnt_q == CW'(DIGITS - 1)) | rest_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bm1_q       <= 1'b0;
            p_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= {{N{a_in[N-1]}}, a_in};
                        b_q        <= b_in;
                        bm1_q      <= 1'b0;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end

                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    bm1_q <= bm1_d;
                    p_q   <= p_d;
                    cnt_q <= cnt_d;
                    if (last_digit) begin
                        out_valid_q <= 1'b1;
                        product_q   <= p_d;
                        state_q     <= DONE;
                    end
                end

                DONE: begin
                    // in_valid is deliberately not looked at here; a new
                    // operand pair is only taken once back in IDLE.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        product_q   <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    product_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule
